data_mem_fetch_ctrl: RTL and testbench



---
 rtl/wino_mem_pkg.sv | 17 +
 rtl/data_mem_fetch_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_data_mem_fetch_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wino_mem_pkg.sv
// rtl/wino_mem_pkg.sv - shared constants and fetch FSM state type for the Winograd input data memory
package wino_mem_pkg;

    localparam int MEM_DEPTH   = 128;
    localparam int ADDR_W      = 8;
    localparam int CH_W        = 4;
    localparam int TILE_ROWS   = 4;
    localparam int TILE_STRIDE = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/data_mem_fetch_ctrl.sv
// rtl/data_mem_fetch_ctrl.sv - dual-port read-address sequencer for F(2x2,3x3) input tiles
// Optional stall counter output enabled by DATA_MEM_FETCH_CTRL_PERF_EN.
module data_mem_fetch_ctrl #(
    parameter int ADDR_W    = wino_mem_pkg::ADDR_W,
    parameter int MEM_DEPTH = wino_mem_pkg::MEM_DEPTH,
    parameter int CH_W      = wino_mem_pkg::CH_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_num_rows,
    input  logic [CH_W-1:0]   cfg_num_ch,
    input  logic              scan_mode,
    input  logic              ready_in,
    output logic [ADDR_W-1:0] addr_1_out,
    output logic [ADDR_W-1:0] addr_2_out,
    output logic              package_1_valid_out,
    output logic              package_2_valid_out,
    output logic [CH_W-1:0]   ch_out,
    output logic [ADDR_W-2:0] tile_out,
    output logic              phase_out,
    output logic              last_out,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
`ifdef DATA_MEM_FETCH_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    import wino_mem_pkg::*;

    localparam int SPAN_W = ADDR_W + CH_W + 1;

    fetch_state_t      state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-2:0] tile_q, tile_d;
    logic [ADDR_W-1:0] chbase_q, chbase_d;
    logic [ADDR_W-1:0] rows_q, rows_d;
    logic [ADDR_W-2:0] tlast_q, tlast_d;
    logic [CH_W-1:0]   chlast_q, chlast_d;

    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic              vld_q, vld_d;
    logic [CH_W-1:0]   ch_out_q, ch_out_d;
    logic [ADDR_W-2:0] tile_out_q, tile_out_d;
    logic              phase_q, phase_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [SPAN_W-1:0] span;
    logic              cfg_ok;
    logic              launch;
    logic [ADDR_W-1:0] row;

    // Range check is done wide so a large base plus image can never wrap into range.
    always_comb begin
        span   = SPAN_W'(cfg_base_addr) + SPAN_W'(cfg_num_ch) * SPAN_W'(cfg_num_rows);
        cfg_ok = !cfg_num_rows[0] && (cfg_num_rows >= ADDR_W'(TILE_ROWS))
                 && (cfg_num_ch != '0) && (span <= SPAN_W'(MEM_DEPTH));
        launch = (state_q == IDLE) && start && !scan_mode;
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        tile_d   = tile_q;
        chbase_d = chbase_q;
        rows_d   = rows_q;
        tlast_d  = tlast_q;
        chlast_d = chlast_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    if (cfg_ok) begin
                        state_d  = LO;
                        ch_d     = '0;
                        tile_d   = '0;
                        chbase_d = cfg_base_addr;
                        rows_d   = cfg_num_rows;
                        tlast_d  = (ADDR_W-1)'((cfg_num_rows >> 1) - ADDR_W'(2));
                        chlast_d = cfg_num_ch - CH_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LO: begin
                if (scan_mode) begin
                    state_d = IDLE;
                end else if (ready_in) begin
                    state_d = HI;
                end
            end
            HI: begin
                if (scan_mode) begin
                    state_d = IDLE;
                end else if (ready_in) begin
                    if (tile_q == tlast_q) begin
                        if (ch_q == chlast_q) begin
                            state_d = FIN;
                        end else begin
                            state_d  = LO;
                            tile_d   = '0;
                            ch_d     = ch_q + CH_W'(1);
                            chbase_d = chbase_q + rows_q;
                        end
                    end else begin
                        state_d = LO;
                        tile_d  = tile_q + (ADDR_W-1)'(1);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state will present.
    always_comb begin
        vld_d      = (state_d == LO) || (state_d == HI);
        row        = chbase_d + {tile_d, 1'b0};
        addr1_d    = '0;
        addr2_d    = '0;
        ch_out_d   = '0;
        tile_out_d = '0;
        phase_d    = 1'b0;
        last_d     = 1'b0;
        if (vld_d) begin
            addr1_d    = row + ((state_d == HI) ? ADDR_W'(TILE_STRIDE) : '0);
            addr2_d    = addr1_d + ADDR_W'(1);
            ch_out_d   = ch_d;
            tile_out_d = tile_d;
            phase_d    = (state_d == HI);
            last_d     = (state_d == HI) && (tile_d == tlast_d) && (ch_d == chlast_d);
        end
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            tile_q     <= '0;
            chbase_q   <= '0;
            rows_q     <= '0;
            tlast_q    <= '0;
            chlast_q   <= '0;
            addr1_q    <= '0;
            addr2_q    <= '0;
            vld_q      <= 1'b0;
            ch_out_q   <= '0;
            tile_out_q <= '0;
            phase_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            tile_q     <= tile_d;
            chbase_q   <= chbase_d;
            rows_q     <= rows_d;
            tlast_q    <= tlast_d;
            chlast_q   <= chlast_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            vld_q      <= vld_d;
            ch_out_q   <= ch_out_d;
            tile_out_q <= tile_out_d;
            phase_q    <= phase_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef DATA_MEM_FETCH_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (launch && cfg_ok) begin
            stall_d = '0;
        end else if (vld_q && !ready_in && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign addr_1_out          = addr1_q;
    assign addr_2_out          = addr2_q;
    assign package_1_valid_out = vld_q;
    assign package_2_valid_out = vld_q;
    assign ch_out              = ch_out_q;
    assign tile_out            = tile_out_q;
    assign phase_out           = phase_q;
    assign last_out            = last_q;
    assign busy                = vld_q;
    assign done                = done_q;
    assign cfg_err             = err_q;

endmodule

// File: tb/tb_data_mem_fetch_ctrl.sv
// tb/tb_data_mem_fetch_ctrl.sv - randomized self-checking bench for data_mem_fetch_ctrl
module tb_data_mem_fetch_ctrl;
    localparam int AW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, start, scan_mode, ready_in;
    logic [AW-1:0] cfg_base_addr, cfg_num_rows;
    logic [CW-1:0] cfg_num_ch;
    logic [AW-1:0] addr_1_out, addr_2_out;
    logic          package_1_valid_out, package_2_valid_out;
    logic [CW-1:0] ch_out;
    logic [AW-2:0] tile_out;
    logic          phase_out, last_out, busy, done, cfg_err;
`ifdef DATA_MEM_FETCH_CTRL_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_fetch_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .cfg_base_addr       (cfg_base_addr),
        .cfg_num_rows        (cfg_num_rows),
        .cfg_num_ch          (cfg_num_ch),
        .scan_mode           (scan_mode),
        .ready_in            (ready_in),
        .addr_1_out          (addr_1_out),
        .addr_2_out          (addr_2_out),
        .package_1_valid_out (package_1_valid_out),
        .package_2_valid_out (package_2_valid_out),
        .ch_out              (ch_out),
        .tile_out            (tile_out),
        .phase_out           (phase_out),
        .last_out            (last_out),
        .busy                (busy),
        .done                (done),
        .cfg_err             (cfg_err)
`ifdef DATA_MEM_FETCH_CTRL_PERF_EN
        ,
        .stall_cnt           (stall_cnt)
`endif
    );

    typedef struct {
        int a1;
        int a2;
        int ch;
        int tile;
        int ph;
        bit last;
    } beat_t;

    beat_t exp_q[$];

    function automatic logic [47:0] all_outs();
        return {addr_1_out, addr_2_out, package_1_valid_out, package_2_valid_out, ch_out,
                tile_out, phase_out, last_out, busy, done, cfg_err, 12'd0};
    endfunction

    // Reference beat list: every tile of every channel, LO then HI.
    task automatic build_model(input int base, input int rows, input int nch);
        int t;
        beat_t b;
        t = rows / 2 - 1;
        exp_q.delete();
        for (int c = 0; c < nch; c++) begin
            for (int k = 0; k < t; k++) begin
                for (int p = 0; p < 2; p++) begin
                    b.a1   = base + c * rows + 2 * k + 2 * p;
                    b.a2   = b.a1 + 1;
                    b.ch   = c;
                    b.tile = k;
                    b.ph   = p;
                    b.last = (c == nch - 1) && (k == t - 1) && (p == 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic run_job(input string name, input int base, input int rows, input int nch,
                           input int stall_pct, input int hold_beat, input int hold_len);
        int idx = 0;
        int cyc = 0;
        int stalls = 0;
        int held = 0;
        int busy_cyc = 0;
        beat_t e;
        build_model(base, rows, nch);
        @(negedge clk);
        cfg_base_addr = AW'(base);
        cfg_num_rows  = AW'(rows);
        cfg_num_ch    = CW'(nch);
        start         = 1'b1;
        ready_in      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (package_1_valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL %s first_valid got %b want 1", name, package_1_valid_out);
        end
        while (idx < exp_q.size() && cyc < 2000) begin
            e = exp_q[idx];
            vectors++;
            if (package_1_valid_out !== 1'b1 || package_2_valid_out !== 1'b1 || busy !== 1'b1 ||
                addr_1_out !== AW'(e.a1) || addr_2_out !== AW'(e.a2) || ch_out !== CW'(e.ch) ||
                tile_out !== (AW-1)'(e.tile) || phase_out !== e.ph[0] || last_out !== e.last ||
                done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s beat%0d got a1=%0d a2=%0d v=%b%b ch=%0d t=%0d ph=%b last=%b busy=%b done=%b want a1=%0d a2=%0d ch=%0d t=%0d ph=%0d last=%b",
                         name, idx, addr_1_out, addr_2_out, package_1_valid_out, package_2_valid_out,
                         ch_out, tile_out, phase_out, last_out, busy, done,
                         e.a1, e.a2, e.ch, e.tile, e.ph, e.last);
            end
            if (busy === 1'b1) busy_cyc++;
            if (idx == hold_beat && held < hold_len) begin
                ready_in = 1'b0;
                held++;
            end else if (hold_len == 0 && $urandom_range(0, 99) < stall_pct) begin
                ready_in = 1'b0;
            end else begin
                ready_in = 1'b1;
            end
            if (!ready_in) stalls++;
            @(posedge clk);
            if (ready_in) idx++;
            @(negedge clk);
            cyc++;
        end
        ready_in = 1'b1;
        vectors++;
        if (cyc >= 2000) begin
            miscompares++;
            $display("FAIL %s timeout got %0d beats want %0d", name, idx, exp_q.size());
        end
        vectors++;
        if (done !== 1'b1 || package_1_valid_out !== 1'b0 || busy !== 1'b0 || last_out !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse got done=%b v=%b busy=%b last=%b want 1 0 0 0",
                     name, done, package_1_valid_out, busy, last_out);
        end
        vectors++;
        if (busy_cyc !== exp_q.size() + stalls) begin
            miscompares++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cyc, exp_q.size() + stalls);
        end
`ifdef DATA_MEM_FETCH_CTRL_PERF_EN
        vectors++;
        if (stall_cnt !== 16'(stalls)) begin
            miscompares++;
            $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, stalls);
        end
`endif
        // A start landing on the done cycle must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || package_1_valid_out !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done got done=%b v=%b busy=%b err=%b want 0 0 0 0",
                     name, done, package_1_valid_out, busy, cfg_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outs() !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0", all_outs());
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (all_outs() !== 48'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle got %h want 0", all_outs());
        end
    endtask

    task automatic test_directed();
        run_job("rows6_ch1", 0, 6, 1, 0, -1, 0);
        run_job("rows4_ch2", 10, 4, 2, 0, -1, 0);
        run_job("backpressure", 0, 6, 1, 0, 1, 3);
        run_job("full_mem", 0, 32, 4, 0, -1, 0);
    endtask

    task automatic test_cfg_err();
        int bad[4][3] = '{'{0, 5, 1}, '{0, 2, 1}, '{0, 6, 0}, '{100, 16, 2}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cfg_base_addr = AW'(bad[i][0]);
            cfg_num_rows  = AW'(bad[i][1]);
            cfg_num_ch    = CW'(bad[i][2]);
            start         = 1'b1;
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (cfg_err !== 1'b1 || package_1_valid_out !== 1'b0 || package_2_valid_out !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL cfg_err%0d got err=%b v=%b%b busy=%b want 1 00 0",
                         i, cfg_err, package_1_valid_out, package_2_valid_out, busy);
            end
            @(negedge clk);
            vectors++;
            if (cfg_err !== 1'b0 || package_1_valid_out !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL cfg_err_pulse%0d got err=%b v=%b busy=%b want 0 0 0",
                         i, cfg_err, package_1_valid_out, busy);
            end
        end
        // Start under scan mode is ignored, even with a bad config.
        scan_mode = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || package_1_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_start got err=%b busy=%b v=%b want 0 0 0", cfg_err, busy, package_1_valid_out);
        end
        scan_mode = 1'b0;
    endtask

    task automatic test_scan_abort();
        @(negedge clk);
        cfg_base_addr = 8'd20;
        cfg_num_rows  = 8'd8;
        cfg_num_ch    = 4'd1;
        ready_in      = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (addr_1_out !== 8'd22 || addr_2_out !== 8'd23 || package_1_valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_beat2 got a1=%0d a2=%0d v=%b want 22 23 1", addr_1_out, addr_2_out, package_1_valid_out);
        end
        scan_mode = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (package_1_valid_out !== 1'b0 || package_2_valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_idle%0d got v=%b%b busy=%b done=%b want 00 0 0",
                         i, package_1_valid_out, package_2_valid_out, busy, done);
            end
            @(negedge clk);
        end
        scan_mode = 1'b0;
        run_job("restart_after_abort", 20, 8, 1, 0, -1, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cfg_base_addr = 8'd4;
        cfg_num_rows  = 8'd8;
        cfg_num_ch    = 4'd2;
        ready_in      = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (all_outs() !== 48'd0) begin
            miscompares++;
            $display("FAIL async_reset got %h want 0", all_outs());
        end
        @(negedge clk);
        reset = 1'b0;
        run_job("after_reset", 4, 8, 2, 0, -1, 0);
    endtask

    task automatic test_random();
        int rows, nch, base;
        for (int i = 0; i < 12; i++) begin
            rows = 2 * $urandom_range(2, 16);
            nch  = $urandom_range(1, 4);
            base = $urandom_range(0, 128 - nch * rows);
            run_job($sformatf("rand%0d", i), base, rows, nch, 30, -1, 0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        scan_mode     = 1'b0;
        ready_in      = 1'b0;
        cfg_base_addr = '0;
        cfg_num_rows  = '0;
        cfg_num_ch    = '0;
        test_reset();
        test_directed();
        test_cfg_err();
        test_scan_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
